// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: stuffing length, de-stuffer states, bus levels.
package can_pkg;

  localparam int CAN_STUFF_LEN = 5;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  typedef enum logic {
    DS_COUNT,
    DS_EXPECT_STUFF
  } destuff_state_t;

endpackage

// File: rtl/can_bit_destuffer_if.sv
// Sampler/decoder-side signal bundle of the CAN bit de-stuffer.
interface can_bit_destuffer_if #(
  parameter int CNT_W = 8
);
  logic             reset_mode;
  logic             sample_point;
  logic             rx_bit;
  logic             bit_destuff_en;
  logic             err_clr;
  logic             rx_data_bit;
  logic             rx_data_valid;
  logic             remove_stuff_bit;
  logic             stuff_err;
  logic             stuff_err_sticky;
  logic             expect_stuff;
  logic [CNT_W-1:0] stuff_cnt;

  modport master (
    output reset_mode, sample_point, rx_bit, bit_destuff_en, err_clr,
    input  rx_data_bit, rx_data_valid, remove_stuff_bit, stuff_err,
           stuff_err_sticky, expect_stuff, stuff_cnt
  );

  modport slave (
    input  reset_mode, sample_point, rx_bit, bit_destuff_en, err_clr,
    output rx_data_bit, rx_data_valid, remove_stuff_bit, stuff_err,
           stuff_err_sticky, expect_stuff, stuff_cnt
  );
endinterface

// File: rtl/can_bit_destuffer.sv
// CAN receive bit de-stuffer: drops the complementary bit after STUFF_LEN equal
// bits, flags a stuff error when that bit repeats, forwards all other bits.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CNT_W     = 8
) (
  input logic                clk,
  input logic                rst,
  can_bit_destuffer_if.slave bus
);

  localparam int             CW     = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0]  LP_LEN = CW'(STUFF_LEN);

  destuff_state_t   r_state, w_state_nxt;
  logic [CW-1:0]    r_run, w_run_nxt, w_run_inc;
  logic             r_prev, w_prev_nxt;
  logic             r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_remove, w_remove_nxt;
  logic             r_err, w_err_nxt;
  logic             r_sticky, w_sticky_nxt;
  logic [CNT_W-1:0] r_scnt, w_scnt_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_prev_nxt   = r_prev;
    w_data_nxt   = r_data;
    w_valid_nxt  = 1'b0;
    w_remove_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    w_sticky_nxt = r_sticky & ~bus.err_clr;
    w_scnt_nxt   = r_scnt;
    w_run_inc    = ((r_run != '0) && (bus.rx_bit == r_prev)) ? r_run + 1'b1 : CW'(1);

    if (bus.sample_point) begin
      if (!bus.bit_destuff_en) begin
        // Pass-through also abandons a pending stuff expectation.
        w_valid_nxt = 1'b1;
        w_data_nxt  = bus.rx_bit;
        w_run_nxt   = '0;
        w_state_nxt = DS_COUNT;
      end else begin
        unique case (r_state)
          DS_COUNT: begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = bus.rx_bit;
            w_run_nxt   = w_run_inc;
            w_prev_nxt  = bus.rx_bit;
            if (w_run_inc == LP_LEN) w_state_nxt = DS_EXPECT_STUFF;
          end
          DS_EXPECT_STUFF: begin
            if (bus.rx_bit != r_prev) begin
              w_remove_nxt = 1'b1;
              if (r_scnt != '1) w_scnt_nxt = r_scnt + 1'b1;
            end else begin
              w_err_nxt    = 1'b1;
              w_sticky_nxt = 1'b1;
            end
            w_run_nxt   = CW'(1);
            w_prev_nxt  = bus.rx_bit;
            w_state_nxt = DS_COUNT;
          end
          default: w_state_nxt = DS_COUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.reset_mode) begin
      r_state  <= DS_COUNT;
      r_run    <= '0;
      r_prev   <= CAN_RECESSIVE;
      r_data   <= 1'b0;
      r_valid  <= 1'b0;
      r_remove <= 1'b0;
      r_err    <= 1'b0;
      r_scnt   <= '0;
      r_sticky <= rst ? 1'b0 : r_sticky;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_prev   <= w_prev_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_remove <= w_remove_nxt;
      r_err    <= w_err_nxt;
      r_scnt   <= w_scnt_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  assign bus.rx_data_bit      = r_data;
  assign bus.rx_data_valid    = r_valid;
  assign bus.remove_stuff_bit = r_remove;
  assign bus.stuff_err        = r_err;
  assign bus.stuff_err_sticky = r_sticky;
  assign bus.expect_stuff     = (r_state == DS_EXPECT_STUFF);
  assign bus.stuff_cnt        = r_scnt;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer; per-bit expectations go through a scoreboard queue.
module tb_can_bit_destuffer;

  localparam logic [2:0] V = 3'b100;  // rx_data_valid
  localparam logic [2:0] R = 3'b010;  // remove_stuff_bit
  localparam logic [2:0] E = 3'b001;  // stuff_err

  typedef struct {
    logic [2:0] flags;
    logic       data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic last_data = 1'b0;
  exp_t sb[$];

  can_bit_destuffer_if #(.CNT_W(8)) bus ();

  can_bit_destuffer #(.STUFF_LEN(5), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic [2:0] f);
    exp_t e;
    e.flags = f;
    e.data  = f[2] ? b : last_data;
    if (f[2]) last_data = b;
    sb.push_back(e);
    bus.rx_bit       = b;
    bus.sample_point = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_point = 1'b0;
    e = sb.pop_front();
    chk("pulses", {29'd0, bus.rx_data_valid, bus.remove_stuff_bit, bus.stuff_err}, {29'd0, e.flags});
    chk("rx_data_bit", {31'd0, bus.rx_data_bit}, {31'd0, e.data});
  endtask

  task automatic idle_chk();
    @(posedge clk);
    #1;
    chk("idle_pulses", {29'd0, bus.rx_data_valid, bus.remove_stuff_bit, bus.stuff_err}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_data = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.reset_mode     = 1'b0;
    bus.sample_point   = 1'b0;
    bus.rx_bit         = 1'b1;
    bus.bit_destuff_en = 1'b1;
    bus.err_clr        = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_outputs", {25'd0, bus.rx_data_bit, bus.rx_data_valid, bus.remove_stuff_bit,
        bus.stuff_err, bus.stuff_err_sticky, bus.expect_stuff, 1'b0}, 32'd0);
    chk("rst_stuff_cnt", {24'd0, bus.stuff_cnt}, 32'd0);
    rst = 1'b0;

    // No stuffing
    send(0, V); send(1, V); send(0, V); send(0, V);
    send(1, V); send(1, V); send(1, V); send(0, V);
    idle_chk();
    chk("nostuff_cnt", {24'd0, bus.stuff_cnt}, 32'd0);

    // Legal stuff bit
    do_reset();
    send(0, V); send(0, V); send(0, V); send(0, V);
    chk("expect_before5", {31'd0, bus.expect_stuff}, 32'd0);
    send(0, V);
    chk("expect_after5", {31'd0, bus.expect_stuff}, 32'd1);
    send(1, R);
    chk("expect_cleared", {31'd0, bus.expect_stuff}, 32'd0);
    send(0, V); send(1, V);
    chk("legal_cnt", {24'd0, bus.stuff_cnt}, 32'd1);

    // Stuff bit starts the next run
    do_reset();
    repeat (5) send(1, V);
    send(0, R);
    repeat (4) send(0, V);
    chk("run_expect", {31'd0, bus.expect_stuff}, 32'd1);
    send(1, R);
    idle_chk();
    chk("run_cnt", {24'd0, bus.stuff_cnt}, 32'd2);

    // Stuff error, clear, then error set wins over simultaneous clear
    do_reset();
    repeat (5) send(1, V);
    send(1, E);
    chk("err_sticky", {31'd0, bus.stuff_err_sticky}, 32'd1);
    chk("err_no_expect", {31'd0, bus.expect_stuff}, 32'd0);
    idle_chk();
    chk("sticky_holds", {31'd0, bus.stuff_err_sticky}, 32'd1);
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    chk("sticky_cleared", {31'd0, bus.stuff_err_sticky}, 32'd0);
    repeat (4) send(1, V);
    bus.err_clr = 1'b1;
    send(1, E);
    bus.err_clr = 1'b0;
    chk("set_beats_clr", {31'd0, bus.stuff_err_sticky}, 32'd1);
    chk("err_cnt_unchanged", {24'd0, bus.stuff_cnt}, 32'd0);

    // Enable boundary
    do_reset();
    chk("rst_clears_sticky", {31'd0, bus.stuff_err_sticky}, 32'd0);
    bus.bit_destuff_en = 1'b0;
    repeat (8) send(0, V);
    chk("passthru_expect", {31'd0, bus.expect_stuff}, 32'd0);
    bus.bit_destuff_en = 1'b1;
    repeat (5) send(0, V);
    chk("en_expect", {31'd0, bus.expect_stuff}, 32'd1);
    bus.bit_destuff_en = 1'b0;
    send(0, V);
    chk("en_drop_expect", {31'd0, bus.expect_stuff}, 32'd0);
    chk("en_drop_sticky", {31'd0, bus.stuff_err_sticky}, 32'd0);
    chk("en_drop_cnt", {24'd0, bus.stuff_cnt}, 32'd0);
    bus.bit_destuff_en = 1'b1;

    // reset_mode mid-run keeps the sticky error
    do_reset();
    repeat (5) send(1, V);
    send(1, R ^ R ^ E);
    repeat (4) send(0, V);
    bus.reset_mode = 1'b1;
    @(posedge clk); #1;
    bus.reset_mode = 1'b0;
    last_data = 1'b0;
    chk("rm_sticky_kept", {31'd0, bus.stuff_err_sticky}, 32'd1);
    chk("rm_expect", {31'd0, bus.expect_stuff}, 32'd0);
    send(0, V); send(0, V);
    chk("rm_no_expect", {31'd0, bus.expect_stuff}, 32'd0);
    do_reset();
    chk("rst_sticky", {31'd0, bus.stuff_err_sticky}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_bit_destuffer.md
Name: can_bit_destuffer

Overview:
- Receive-side counterpart of the CAN transmit bit stuffer.
- On every sample point it takes the sampled bus bit and tracks runs of identical bits. It removes the complementary stuff bit that follows STUFF_LEN equal bits, and flags a stuff error when that bit is not complementary.
- Sits between the bit-timing sampler and the receive frame decoder. Only de-stuffed bits reach the decoder, each qualified by a one-cycle valid pulse.

Parameters:
- STUFF_LEN, 5, number of consecutive equal bits after which a stuff bit is mandatory (legal range 2..7).
- CNT_W, 8, width of the saturating removed-stuff-bit counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- reset_mode  input  1  controller in reset mode; clears all state the same way as rst, except that stuff_err_sticky is held.
- sample_point  input  1  one-cycle strobe: rx_bit is valid this cycle.
- rx_bit  input  1  sampled bus level (1 = recessive).
- bit_destuff_en  input  1  de-stuffing active (SOF through CRC sequence).
- err_clr  input  1  clears stuff_err_sticky.
- rx_data_bit  output  1  de-stuffed data bit.
- rx_data_valid  output  1  one-cycle pulse: rx_data_bit holds a new data bit.
- remove_stuff_bit  output  1  one-cycle pulse: the bit sampled was a stuff bit and was dropped.
- stuff_err  output  1  one-cycle pulse: stuff rule violated.
- stuff_err_sticky  output  1  latched stuff error.
- expect_stuff  output  1  status: the next sampled bit is a stuff bit.
- stuff_cnt  output  CNT_W  saturating count of removed stuff bits.

Behaviour:
- Reset (rst=1 at posedge clk): all outputs 0; run counter 0; prev_bit 1; state COUNT.
- reset_mode=1: same clearing as rst, except stuff_err_sticky is held.
- Priority: rst > reset_mode > err_clr/sample_point processing.
- All outputs are registered. Pulses appear in the cycle after the sample_point cycle and last exactly one cycle. With no sample_point, the pulse outputs are 0.
- rx_data_bit holds its last value between valid pulses.
- Run counter: width $clog2(STUFF_LEN+1). A value of 0 means "no history".
- bit_destuff_en=0 at a sample_point:
  - rx_data_valid=1, rx_data_bit=rx_bit (pass-through).
  - Counter forced to 0, state forced to COUNT, no stuff checks.
- State COUNT (en=1, sample_point):
  - Emit rx_data_valid=1 with rx_data_bit=rx_bit.
  - If counter!=0 and rx_bit==prev_bit: counter+1. Otherwise counter=1.
  - prev_bit=rx_bit.
  - If the new counter value == STUFF_LEN: go to EXPECT_STUFF and set expect_stuff=1.
- State EXPECT_STUFF (en=1, sample_point):
  - rx_data_valid stays 0; the bit is never forwarded.
  - rx_bit != prev_bit (legal stuff bit):
    - remove_stuff_bit=1; stuff_cnt+1, saturating at all-ones.
    - counter=1 (the stuff bit starts the next run); prev_bit=rx_bit.
    - Go to COUNT.
  - rx_bit == prev_bit (stuff error):
    - stuff_err=1, stuff_err_sticky=1.
    - counter=1, prev_bit=rx_bit; go to COUNT.
  - The decoder is responsible for error-frame handling.
- bit_destuff_en falling while in EXPECT_STUFF: the next sample_point is treated as pass-through (en=0 rule), with no error and no removal.
- stuff_err_sticky:
  - Set on a stuff error.
  - Cleared by err_clr when no error occurs in the same cycle; set wins over a simultaneous err_clr.
- expect_stuff is 1 exactly while state==EXPECT_STUFF.
- stuff_cnt clears on rst and on reset_mode.

Decomposition:
- Shared package can_pkg:
  - CAN_STUFF_LEN = 5.
  - enum destuff_state_t {DS_COUNT, DS_EXPECT_STUFF}.
  - CAN_DOMINANT = 1'b0 and CAN_RECESSIVE = 1'b1.
- The design is a single module with no sub-module. The saturating counter is inline.

Test Plan:
- No stuffing: en=1, bits 0,1,0,0,1,1,1,0 → 8 valid pulses with the same values; remove_stuff_bit and stuff_err never assert.
- Legal stuff: en=1, bits 0,0,0,0,0,1(stuff),0,1 →
  - expect_stuff high after the 5th bit;
  - the 6th bit gives remove_stuff_bit=1 with no valid;
  - valid bits are 0,0,0,0,0,0,1;
  - stuff_cnt=1.
- Stuff bit starts a new run: 1,1,1,1,1,0(stuff),0,0,0,0,1(stuff) → two removals and 9 valid bits; stuff_cnt=2.
- Stuff error: 1×6 with en=1 → 6th bit gives stuff_err pulse, stuff_err_sticky=1, no valid for that bit. Then err_clr=1 → sticky returns to 0.
- Enable boundary:
  - en=0 with 8 equal bits → all passed through, no removal.
  - Then set en=1 with 5 zeros → expect_stuff=1.
  - Drop en → the next 0 passes through with valid=1 and no error.
- Reset mid-operation: after 4 equal bits, pulse reset_mode one cycle → counter cleared. Two further equal bits do not set expect_stuff; stuff_err_sticky is retained across reset_mode and cleared by rst.
